// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Owns the register file's single write port. After reset it sweeps
//   registers 1..NUM_REGS-1 to zero. It then arbitrates between two writeback
//   requesters (req0: ALU, req1: load) with round-robin priority and a
//   valid/ready handshake.
//
// Ports
//   clock, reset         : rising-edge clock, asynchronous active-high reset
//   reqN_valid/addr/data : requester N write request (held until accepted)
//   reqN_ready           : requester N accepted this cycle (combinational)
//   init_busy            : high while the reset sweep is running
//   wr_en/wr_addr/wr_data: registered drive of regWrite/writeReg/writeData
//   grant_id             : requester that produced the current wr_en pulse
module regfile_write_arbiter #(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              init_busy,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              grant_id
);

  // One extra bit so the counter can reach NUM_REGS, which marks the sweep
  // as finished without wrapping back to an address already swept.
  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_grant_q, last_grant_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              grant_id_q, grant_id_d;
  logic              init_busy_q, init_busy_d;

  logic              sweep_done;
  logic              gnt0, gnt1;
  logic              xfer0, xfer1;

  assign sweep_done = (cnt_q == CNT_W'(NUM_REGS));

  // Round-robin: with both valid, the requester that did not win last time wins.
  assign gnt0 = req0_valid && (!req1_valid || last_grant_q);
  assign gnt1 = req1_valid && (!req0_valid || !last_grant_q);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_INIT: if (sweep_done) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Output logic: handshake is combinational from valid and last_grant
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state_q == ST_RUN) begin
      req0_ready = gnt0;
      req1_ready = gnt1;
    end
  end

  assign xfer0 = req0_valid && req0_ready;
  assign xfer1 = req1_valid && req1_ready;

  // Write-port datapath next values
  always_comb begin
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    grant_id_d   = grant_id_q;
    init_busy_d  = init_busy_q;
    if (state_q == ST_INIT) begin
      init_busy_d = !sweep_done;
      if (!sweep_done) begin
        wr_en_d   = 1'b1;
        wr_addr_d = cnt_q[ADDR_W-1:0];
        wr_data_d = '0;
        cnt_d     = cnt_q + CNT_W'(1);
      end
    end else begin
      init_busy_d = 1'b0;
      // A write to r0 is accepted and counts for fairness but never pulses wr_en.
      if (xfer0) begin
        last_grant_d = 1'b0;
        if (req0_addr != '0) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = req0_addr;
          wr_data_d  = req0_data;
          grant_id_d = 1'b0;
        end
      end else if (xfer1) begin
        last_grant_d = 1'b1;
        if (req1_addr != '0) begin
          wr_en_d    = 1'b1;
          wr_addr_d  = req1_addr;
          wr_data_d  = req1_data;
          grant_id_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q        <= CNT_W'(1);
      last_grant_q <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      grant_id_q   <= 1'b0;
      init_busy_q  <= 1'b1;
    end else begin
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      grant_id_q   <= grant_id_d;
      init_busy_q  <= init_busy_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;
  assign grant_id  = grant_id_q;
  assign init_busy = init_busy_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter with a behavioural register file
// that samples the write port on the falling edge.
module tb_regfile_write_arbiter;

  logic        clock;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [4:0]  req0_addr, req1_addr;
  logic [31:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        init_busy, wr_en, grant_id;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  logic [31:0] rf [32];
  logic        preload;

  int n_chk  = 0;
  int n_pass = 0;

  regfile_write_arbiter #(
    .NUM_REGS(32),
    .ADDR_W  (5),
    .DATA_W  (32)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .req0_valid(req0_valid),
    .req0_addr (req0_addr),
    .req0_data (req0_data),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid),
    .req1_addr (req1_addr),
    .req1_data (req1_data),
    .req1_ready(req1_ready),
    .init_busy (init_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .grant_id  (grant_id)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Register file model: preloaded with non-zero junk so the sweep is visible.
  always @(negedge clock) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'hBAD0_0000 | 32'(i);
    end else if (wr_en) begin
      rf[wr_addr] <= wr_data;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  task automatic idle_reqs();
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
  endtask

  // Runs the 31-write sweep plus the RUN-entry edge, checking each step.
  task automatic sweep(input bit detailed);
    for (int i = 1; i <= 31; i++) begin
      tick();
      if (detailed) begin
        check($sformatf("sweep_en_%0d", i), 64'(wr_en), 64'd1);
        check($sformatf("sweep_addr_%0d", i), 64'(wr_addr), 64'(i));
        check($sformatf("sweep_data_%0d", i), 64'(wr_data), 64'd0);
        check($sformatf("sweep_rdy_%0d", i), 64'({req0_ready, req1_ready}), 64'd0);
      end
    end
    tick();
    check("run_entry_wr_en", 64'(wr_en), 64'd0);
    check("run_entry_busy", 64'(init_busy), 64'd0);
  endtask

  initial begin
    idle_reqs();
    preload = 1'b1;
    reset   = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    preload = 1'b0;
    check("rst_wr_en", 64'(wr_en), 64'd0);
    check("rst_wr_addr", 64'(wr_addr), 64'd0);
    check("rst_wr_data", 64'(wr_data), 64'd0);
    check("rst_grant", 64'(grant_id), 64'd0);
    check("rst_busy", 64'(init_busy), 64'd1);
    check("rst_ready", 64'({req0_ready, req1_ready}), 64'd0);

    // Reset sweep; requests held valid during INIT must still see ready=0.
    reset = 1'b0;
    req0_valid = 1'b1; req0_addr = 5'd2; req0_data = 32'h1111;
    req1_valid = 1'b1; req1_addr = 5'd3; req1_data = 32'h2222;
    #1;
    check("init_ready_held", 64'({req0_ready, req1_ready}), 64'd0);
    idle_reqs();
    sweep(1'b1);
    settle();
    for (int i = 0; i < 32; i++)
      check($sformatf("sweep_rb_r%0d", i), 64'(i == 0 ? 32'd0 : rf[i]), 64'd0);
    // settle moved us mid-cycle; realign to just after a rising edge
    tick();

    // Single requester
    req0_valid = 1'b1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
    #1;
    check("single_rdy0", 64'(req0_ready), 64'd1);
    check("single_rdy1", 64'(req1_ready), 64'd0);
    tick();
    idle_reqs();
    check("single_en", 64'(wr_en), 64'd1);
    check("single_addr", 64'(wr_addr), 64'd5);
    check("single_data", 64'(wr_data), 64'hDEADBEEF);
    check("single_gid", 64'(grant_id), 64'd0);
    tick();
    check("single_en_off", 64'(wr_en), 64'd0);
    check("single_addr_hold", 64'(wr_addr), 64'd5);
    check("single_data_hold", 64'(wr_data), 64'hDEADBEEF);

    // req1 alone, leaving last_grant=1 so req0 wins the next contest
    req1_valid = 1'b1; req1_addr = 5'd6; req1_data = 32'h66;
    #1;
    check("solo1_rdy1", 64'(req1_ready), 64'd1);
    tick();
    idle_reqs();
    check("solo1_gid", 64'(grant_id), 64'd1);

    // Contention: expected grant order 0,1,0,1
    req0_valid = 1'b1; req0_addr = 5'd3; req0_data = 32'd1;
    req1_valid = 1'b1; req1_addr = 5'd4; req1_data = 32'd10;
    #1;
    check("cont0_rdy", 64'({req0_ready, req1_ready}), 64'b10);
    tick();
    check("cont0_w", 64'({wr_en, grant_id, wr_addr, wr_data}), {27'd0, 1'b1, 1'b0, 5'd3, 32'd1});
    req0_data = 32'd2;
    #1;
    check("cont1_rdy", 64'({req0_ready, req1_ready}), 64'b01);
    tick();
    check("cont1_w", 64'({wr_en, grant_id, wr_addr, wr_data}), {27'd0, 1'b1, 1'b1, 5'd4, 32'd10});
    req1_data = 32'd20;
    #1;
    check("cont2_rdy", 64'({req0_ready, req1_ready}), 64'b10);
    tick();
    check("cont2_w", 64'({wr_en, grant_id, wr_addr, wr_data}), {27'd0, 1'b1, 1'b0, 5'd3, 32'd2});
    req0_valid = 1'b0;
    #1;
    check("cont3_rdy", 64'({req0_ready, req1_ready}), 64'b01);
    tick();
    check("cont3_w", 64'({wr_en, grant_id, wr_addr, wr_data}), {27'd0, 1'b1, 1'b1, 5'd4, 32'd20});
    idle_reqs();
    settle();
    check("cont_r3", 64'(rf[3]), 64'd2);
    check("cont_r4", 64'(rf[4]), 64'd20);
    tick();

    // Same address: req0 first (last_grant=1), req1's value is final
    req0_valid = 1'b1; req0_addr = 5'd7; req0_data = 32'hA;
    req1_valid = 1'b1; req1_addr = 5'd7; req1_data = 32'hB;
    #1;
    check("same_rdy_first", 64'({req0_ready, req1_ready}), 64'b10);
    tick();
    check("same_gid_first", 64'(grant_id), 64'd0);
    req0_valid = 1'b0;
    #1;
    check("same_rdy_second", 64'(req1_ready), 64'd1);
    tick();
    check("same_gid_second", 64'(grant_id), 64'd1);
    idle_reqs();
    settle();
    check("same_r7", 64'(rf[7]), 64'hB);
    tick();

    // r0 writes: accepted, no pulse, still counted for round-robin
    req1_valid = 1'b1; req1_addr = 5'd0; req1_data = 32'h55;
    #1;
    check("r0_rdy1", 64'(req1_ready), 64'd1);
    tick();
    idle_reqs();
    check("r0_en1", 64'(wr_en), 64'd0);
    req0_valid = 1'b1; req0_addr = 5'd0; req0_data = 32'h77;
    #1;
    check("r0_rdy0", 64'(req0_ready), 64'd1);
    tick();
    check("r0_en0", 64'(wr_en), 64'd0);
    // req0's r0 write set last_grant=0, so req1 now wins
    req0_addr = 5'd8; req0_data = 32'h8;
    req1_valid = 1'b1; req1_addr = 5'd9; req1_data = 32'h9;
    #1;
    check("r0_rr_rdy", 64'({req0_ready, req1_ready}), 64'b01);
    idle_reqs();

    // Reset mid-sweep at addr 12
    reset = 1'b1;
    #1;
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) tick();
    check("mid_sweep_addr", 64'(wr_addr), 64'd12);
    reset = 1'b1;
    #1;
    check("mid_sweep_en", 64'(wr_en), 64'd0);
    check("mid_sweep_addr0", 64'(wr_addr), 64'd0);
    check("mid_sweep_busy", 64'(init_busy), 64'd1);
    tick();
    reset = 1'b0;
    tick();
    check("restart_en", 64'(wr_en), 64'd1);
    check("restart_addr", 64'(wr_addr), 64'd1);
    for (int i = 2; i <= 31; i++) tick();
    check("restart_last_addr", 64'(wr_addr), 64'd31);
    tick();
    check("restart_run_busy", 64'(init_busy), 64'd0);

    // Reset during a RUN pulse: the pulse must never reach the register file
    req0_valid = 1'b1; req0_addr = 5'd9; req0_data = 32'h1234;
    #1;
    check("kill_rdy", 64'(req0_ready), 64'd1);
    tick();
    idle_reqs();
    check("kill_pulse", 64'(wr_en), 64'd1);
    reset = 1'b1;
    #1;
    check("kill_en", 64'(wr_en), 64'd0);
    check("kill_busy", 64'(init_busy), 64'd1);
    settle();
    check("kill_r9", 64'(rf[9]), 64'd0);
    reset = 1'b0;
    tick();
    check("kill_restart_addr", 64'(wr_addr), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
